// File: rtl/imem_loader_pkg.sv
// loader_pkg : shared constants and FSM encoding for imem_loader / byte_packer.
`default_nettype none

package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_LEN        = 2;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// byte_packer : 2-bit byte counter + little-endian 32-bit word assembly, one-cycle word_valid pulse.
`default_nettype none

module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_shift;

  assign last_byte = (r_cnt == 2'(BYTES_PER_WORD - 1));

  // New bytes enter at the top, so the first byte ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_shift    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        r_cnt   <= r_cnt + 2'd1;
        r_shift <= {byte_data, r_shift[WORD_W-1:8]};
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {byte_data, r_shift[WORD_W-1:8]};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader : byte-stream boot loader writing scpu instruction memory; holds the CPU in reset until done.
// Option: define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [16:0] wcnt;
  logic [7:0]  csum;
  logic        accept;
  logic        last_byte;

  assign accept = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .byte_data  (in_data),
    .byte_valid (accept && (state == S_DATA)),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN_LO;
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      wcnt      <= '0;
      csum      <= '0;
      imem_addr <= '0;
    end else begin
      case (state)
        S_LEN_LO: begin
          in_ready <= 1'b1;
          if (accept) begin
            len[7:0] <= in_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            if ({1'b0, in_data, len[7:0]} > CAP) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if ({in_data, len[7:0]} != 16'd0) begin
              state <= S_DATA;
            end else if (CSUM_EN) begin
              state <= S_CSUM;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              in_ready  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            if (last_byte) begin
              imem_addr <= wcnt[ADDR_W-1:0];
              wcnt      <= wcnt + 17'd1;
              if (wcnt + 17'd1 == {1'b0, len}) begin
                if (CSUM_EN) begin
                  state <= S_CSUM;
                end else begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
                  in_ready  <= 1'b0;
                end
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: in_ready <= 1'b0;  // S_DONE / S_ERROR: terminal until reset
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader : directed + randomized image loads checked against a byte-level reference model.
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 2;
  localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic [7:0]        img[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpurst", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_up", in_ready, 1);
  endtask

  task automatic push_csum(input logic [7:0] tweak);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    if (CSUM_EN) img.push_back(x ^ tweak);
  endtask

  // Derives the expected outcome purely from the byte image, then streams it.
  task automatic run_image(input bit gaps);
    int          n, fin, idx, cyc;
    bit          over, ok, early, v, rdy;
    logic [7:0]  x;
    logic [31:0] ew[$];
    n    = int'({img[1], img[0]});
    over = n > CAP;
    x    = 8'h00;
    if (!over) begin
      for (int i = 0; i < n; i++)
        ew.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
      for (int j = 0; j < 4 * n; j++) x ^= img[2+j];
    end
    ok  = !over && (!CSUM_EN || img[2+4*n] == x);
    fin = over ? 1 : 1 + 4 * n + int'(CSUM_EN);
    wa.delete();
    wd.delete();
    idx   = 0;
    cyc   = 0;
    early = 1'b0;
    while (idx <= fin && cyc < 4000) begin
      rdy      = in_ready;
      v        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? img[idx] : 8'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      if (v && rdy) idx++;
      in_valid = 1'b0;
      if (idx <= fin && (done || error || !cpu_reset)) early = 1'b1;
    end
    chk("timeout", idx, fin + 1);
    chk("early_end", early, 0);
    chk("end_done", done, ok);
    chk("end_error", error, !ok);
    chk("end_cpurst", cpu_reset, !ok);
    chk("end_ready", in_ready, 0);
    chk("end_we", imem_we, !over && n > 0 && !CSUM_EN);
    repeat (4) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("term_ready", in_ready, 0);
    chk("term_flags", {done, error, cpu_reset}, {ok, !ok, !ok});
    chk("nwrites", wd.size(), ew.size());
    for (int i = 0; i < wd.size() && i < ew.size(); i++) begin
      chk("waddr", wa[i], i);
      chk("wdata", wd[i], ew[i]);
    end
  endtask

  initial begin
    int n, r;
    do_reset();

    // Two-word image, back-to-back bytes
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    push_csum(8'h00);
    run_image(1'b0);
    do_reset();

`ifdef IMEM_LOADER_CSUM_EN
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h21};
    run_image(1'b0);
    do_reset();
`endif

    // Oversize header
    img = '{8'h05, 8'h00};
    run_image(1'b0);
    do_reset();

    // Exactly full memory
    img = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) img.push_back(8'(i * 17 + 3));
    push_csum(8'h00);
    run_image(1'b0);
    do_reset();

    // Empty image
    img = '{8'h00, 8'h00};
    push_csum(8'h00);
    run_image(1'b0);
    do_reset();

    // Two-word image with random valid gaps
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    push_csum(8'h00);
    run_image(1'b1);
    do_reset();

    // Reset after 5 payload bytes, then a fresh one-word image
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'h02 : (i == 1) ? 8'h00 : 8'($urandom);
      @(posedge clk);
      #1;
      chk("mid_cpurst", cpu_reset, 1);
    end
    in_valid = 1'b0;
    do_reset();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_csum(8'h00);
    run_image(1'b0);
    do_reset();

    // Randomized images
    for (int t = 0; t < 25; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       n = int'($urandom_range(0, CAP));
      else if (r == 7) n = CAP + 1;
      else             n = int'($urandom_range(CAP + 1, 65535));
      img.delete();
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
      if (n <= CAP) begin
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        push_csum(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      run_image(1'($urandom_range(0, 1)));
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
